lag_canceller: RTL and testbench

Receive-side counterpart of the lag (echo) generator. Keeps a 4-tap history of the far-end reference samples, forms the echo estimate as the weighted sum of those taps with pre-normalised weights, and subtracts it from the received (mic) sample. It sits after the sampling stage on the operation clock and produces one cleaned sample per accepted input. Arithmetic is signed fixed-point Q16.16 through one sequential multiply-accumulate (MAC).

---
 rtl/lag_pkg.sv | 32 +++
 rtl/lag_mac.sv | 33 +++
 rtl/lag_canceller.sv | 150 +++++++++++++++
 tb/tb_lag_canceller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lag_pkg.sv
// lag_pkg: shared constants, FSM state type and the 32-bit reduction
// helper for the lag (echo) canceller.
//
// Build option: LAG_CANCEL_SAT_EN. When defined, reduce() saturates to the
// signed 32-bit range. When undefined, reduce() wraps (drops the high bits).
package lag_pkg;

   localparam int DATA_W = 32;
   localparam int FRAC_W = 16;
   localparam int TAPS   = 4;
   localparam int PROD_W = 2 * DATA_W;   // Q32.32 product
   localparam int ACC_W  = 66;           // sum of 4 products plus sign headroom

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      MAC   = 2'd2,
      SUB   = 2'd3
   } state_t;

   // Reduce a wide signed value to DATA_W bits.
   function automatic logic [DATA_W-1:0] reduce(input logic signed [ACC_W-1:0] v);
`ifdef LAG_CANCEL_SAT_EN
      // The value fits only when every bit from the 32-bit sign bit up to
      // the MSB is equal. Otherwise the top bit gives the clamp direction.
      if (!((&v[ACC_W-1:DATA_W-1]) || !(|v[ACC_W-1:DATA_W-1])))
         return v[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
      return v[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/lag_mac.sv
// lag_mac: one signed DATA_W x DATA_W multiply feeding an ACC_W accumulator.
//   clk_operation : operation clock
//   rst           : asynchronous, active-high reset; clears the accumulator
//   clr           : synchronous clear of the accumulator (has priority over en)
//   en            : add a*b to the accumulator this cycle
//   a, b          : signed Q16.16 operands
//   acc           : signed Q34.32 running sum
module lag_mac
   import lag_pkg::*;
(
   input  logic                     clk_operation,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [ACC_W-1:0]  acc
);

   logic signed [PROD_W-1:0] prod;

   assign prod = a * b;

   always_ff @(posedge clk_operation or posedge rst) begin
      if (rst)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
   end

endmodule

// File: rtl/lag_canceller.sv
// lag_canceller: subtracts a 4-tap weighted echo estimate of the far-end
// reference from the mic sample. Signed Q16.16 throughout, one shared MAC.
//
// Ports:
//   clk_operation, rst (async, active-high)
//   sample_valid, signal_ref, signal_mic : input sample strobe and data
//   para_0..para_3                       : tap weights (para_0 = newest tap),
//                                          latched once per sample
//   clr_overrun                          : clears the sticky overrun flag
//   signal_clean, signal_echo            : results, held until the next sample
//   ready                                : one-cycle pulse when results update
//   busy                                 : high while a sample is in process
//   overrun                              : a sample arrived while busy
//
// Build option: LAG_CANCEL_SAT_EN selects saturating 32-bit results. The
// default is wrapping.
//
// Latency: valid in cycle c, busy in cycles c+1..c+6, ready in cycle c+7.
module lag_canceller #(
   parameter int DATA_W = lag_pkg::DATA_W,
   parameter int FRAC_W = lag_pkg::FRAC_W,
   parameter int TAPS   = lag_pkg::TAPS
) (
   input  logic              clk_operation,
   input  logic              rst,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] signal_ref,
   input  logic [DATA_W-1:0] signal_mic,
   input  logic [DATA_W-1:0] para_0,
   input  logic [DATA_W-1:0] para_1,
   input  logic [DATA_W-1:0] para_2,
   input  logic [DATA_W-1:0] para_3,
   input  logic              clr_overrun,
   output logic [DATA_W-1:0] signal_clean,
   output logic [DATA_W-1:0] signal_echo,
   output logic              ready,
   output logic              busy,
   output logic              overrun
);

   import lag_pkg::state_t;
   import lag_pkg::IDLE;
   import lag_pkg::SHIFT;
   import lag_pkg::MAC;
   import lag_pkg::SUB;
   import lag_pkg::ACC_W;
   import lag_pkg::reduce;

   localparam logic [1:0]              LAST_IDX = 2'(TAPS - 1);
   localparam logic signed [ACC_W-1:0] HALF     = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);

   state_t                    state;
   logic [1:0]                idx;
   logic signed [DATA_W-1:0]  tap [TAPS];
   logic signed [DATA_W-1:0]  w   [TAPS];
   logic signed [DATA_W-1:0]  ref_cap;
   logic signed [DATA_W-1:0]  mic_cap;

   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   acc_rnd;
   logic signed [ACC_W-1:0]   echo_x;
   logic signed [ACC_W-1:0]   mic_x;
   logic [DATA_W-1:0]         echo_q;
   logic [DATA_W-1:0]         clean_q;

   // The taps update at the end of SHIFT, so during MAC tap[0] already holds
   // the current sample. The current sample is part of its own estimate.
   lag_mac u_mac (
      .clk_operation (clk_operation),
      .rst           (rst),
      .clr           (state == SHIFT),
      .en            (state == MAC),
      .a             (tap[idx]),
      .b             (w[idx]),
      .acc           (acc)
   );

   // Round half toward +inf, then return to Q16.16. Clean is formed from the
   // already reduced echo, so the output pair is self-consistent.
   always_comb begin
      acc_rnd = (acc + HALF) >>> FRAC_W;
      echo_q  = reduce(acc_rnd);
      echo_x  = {{(ACC_W-DATA_W){echo_q[DATA_W-1]}}, echo_q};
      mic_x   = {{(ACC_W-DATA_W){mic_cap[DATA_W-1]}}, mic_cap};
      clean_q = reduce(mic_x - echo_x);
   end

   always_ff @(posedge clk_operation or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= '0;
         ref_cap      <= '0;
         mic_cap      <= '0;
         signal_clean <= '0;
         signal_echo  <= '0;
         ready        <= 1'b0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            tap[i] <= '0;
            w[i]   <= '0;
         end
      end else begin
         ready <= 1'b0;

         // A new sample that arrives outside IDLE is dropped. If a set and a
         // clear occur in the same cycle, the set wins.
         if (state != IDLE && sample_valid)
            overrun <= 1'b1;
         else if (clr_overrun)
            overrun <= 1'b0;

         case (state)
            IDLE: begin
               if (sample_valid) begin
                  ref_cap <= signal_ref;
                  mic_cap <= signal_mic;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               for (int i = TAPS - 1; i > 0; i--)
                  tap[i] <= tap[i-1];
               tap[0] <= ref_cap;
               w[0]   <= para_0;
               w[1]   <= para_1;
               w[2]   <= para_2;
               w[3]   <= para_3;
               idx    <= '0;
               state  <= MAC;
            end
            MAC: begin
               idx <= idx + 2'd1;
               if (idx == LAST_IDX)
                  state <= SUB;
            end
            SUB: begin
               signal_echo  <= echo_q;
               signal_clean <= clean_q;
               ready        <= 1'b1;
               busy         <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lag_canceller.sv
// Directed bench for lag_canceller. Expected values are computed by hand in
// Q16.16. Inputs are driven on the falling edge and outputs are sampled
// there, away from the active rising edge.
module tb_lag_canceller;

   logic        clk_operation = 1'b0;
   logic        rst;
   logic        sample_valid;
   logic [31:0] signal_ref, signal_mic;
   logic [31:0] para_0, para_1, para_2, para_3;
   logic        clr_overrun;
   logic [31:0] signal_clean, signal_echo;
   logic        ready, busy, overrun;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_operation = ~clk_operation;

   lag_canceller dut (
      .clk_operation (clk_operation),
      .rst           (rst),
      .sample_valid  (sample_valid),
      .signal_ref    (signal_ref),
      .signal_mic    (signal_mic),
      .para_0        (para_0),
      .para_1        (para_1),
      .para_2        (para_2),
      .para_3        (para_3),
      .clr_overrun   (clr_overrun),
      .signal_clean  (signal_clean),
      .signal_echo   (signal_echo),
      .ready         (ready),
      .busy          (busy),
      .overrun       (overrun)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Valid in cycle c. The task returns at the falling edge of cycle c+1.
   task automatic pulse_valid(input logic [31:0] r, input logic [31:0] m);
      @(negedge clk_operation);
      sample_valid = 1'b1;
      signal_ref   = r;
      signal_mic   = m;
      @(negedge clk_operation);
      sample_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 20) begin
         @(negedge clk_operation);
         n++;
      end
      if (!ready) check("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_sample(input logic [31:0] r, input logic [31:0] m);
      pulse_valid(r, m);
      wait_ready();
   endtask

   task automatic set_w(input logic [31:0] a, b, c, d);
      para_0 = a; para_1 = b; para_2 = c; para_3 = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; sample_valid = 1'b0; signal_ref = '0; signal_mic = '0;
      clr_overrun = 1'b0;
      set_w(32'h8000, 32'h4000, 32'h4000, 32'h0);
      repeat (2) @(negedge clk_operation);
      check("rst_clean",   signal_clean, 32'h0);
      check("rst_echo",    signal_echo,  32'h0);
      check("rst_ready",   {31'd0, ready},   32'h0);
      check("rst_busy",    {31'd0, busy},    32'h0);
      check("rst_overrun", {31'd0, overrun}, 32'h0);
      rst = 1'b0;

      // Sample 1, with the handshake timing checked cycle by cycle.
      pulse_valid(32'h0001_0000, 32'h0001_0000);
      for (int k = 1; k <= 6; k++) begin
         check($sformatf("busy_c+%0d", k),  {31'd0, busy},  32'h1);
         check($sformatf("ready_c+%0d", k), {31'd0, ready}, 32'h0);
         @(negedge clk_operation);
      end
      check("ready_c+7", {31'd0, ready}, 32'h1);
      check("busy_c+7",  {31'd0, busy},  32'h0);
      check("s1_echo",   signal_echo,  32'h0000_8000);
      check("s1_clean",  signal_clean, 32'h0000_8000);
      // Sample 2 is issued in the ready cycle and must be accepted cleanly.
      sample_valid = 1'b1;
      @(negedge clk_operation);
      sample_valid = 1'b0;
      check("ready_c+8",     {31'd0, ready},   32'h0);
      check("busy_back2back", {31'd0, busy},    32'h1);
      check("no_overrun_b2b", {31'd0, overrun}, 32'h0);
      wait_ready();
      check("s2_echo",  signal_echo,  32'h0000_C000);
      check("s2_clean", signal_clean, 32'h0000_4000);
      run_sample(32'h0001_0000, 32'h0001_0000);
      check("s3_echo",  signal_echo,  32'h0001_0000);
      check("s3_clean", signal_clean, 32'h0000_0000);
      run_sample(32'h0001_0000, 32'h0001_0000);
      check("s4_echo",  signal_echo,  32'h0001_0000);
      check("s4_clean", signal_clean, 32'h0000_0000);

      // Overrun: a second valid in cycle c+3 is dropped.
      pulse_valid(32'h0001_0000, 32'h0001_0000);
      repeat (2) @(negedge clk_operation);
      sample_valid = 1'b1; signal_ref = 32'h0005_0000; signal_mic = 32'h0005_0000;
      @(negedge clk_operation);
      sample_valid = 1'b0;
      check("overrun_set", {31'd0, overrun}, 32'h1);
      wait_ready();
      check("ovr_echo",   signal_echo,  32'h0001_0000);
      check("ovr_clean",  signal_clean, 32'h0000_0000);
      repeat (3) @(negedge clk_operation);
      check("overrun_sticky", {31'd0, overrun}, 32'h1);
      clr_overrun = 1'b1;
      @(negedge clk_operation);
      clr_overrun = 1'b0;
      check("overrun_clr", {31'd0, overrun}, 32'h0);
      // Taps [0,1,1,1]. A 5.0 inserted in the history would change this.
      pulse_valid(32'h0, 32'h0);
      sample_valid = 1'b1; clr_overrun = 1'b1; signal_ref = 32'h0007_0000;
      @(negedge clk_operation);
      sample_valid = 1'b0; clr_overrun = 1'b0;
      check("set_wins", {31'd0, overrun}, 32'h1);
      wait_ready();
      check("hist_echo",  signal_echo,  32'h0000_8000);
      check("hist_clean", signal_clean, 32'hFFFF_8000);
      run_sample(32'h0, 32'h0);
      check("hist2_echo", signal_echo, 32'h0000_4000);

      // Reduction of clean to 32 bits.
      set_w(32'h0001_0000, 32'h0, 32'h0, 32'h0);
      run_sample(32'h7FFF_FFFF, 32'h8000_0000);
      check("big_echo", signal_echo, 32'h7FFF_FFFF);
`ifdef LAG_CANCEL_SAT_EN
      check("sat_clean", signal_clean, 32'h8000_0000);
`else
      check("wrap_clean", signal_clean, 32'h0000_0001);
`endif

      // Reset during MAC clears everything immediately.
      pulse_valid(32'h0001_0000, 32'h0);
      repeat (2) @(negedge clk_operation);
      rst = 1'b1;
      #1;
      check("midrst_busy",  {31'd0, busy},  32'h0);
      check("midrst_ready", {31'd0, ready}, 32'h0);
      check("midrst_echo",  signal_echo,  32'h0);
      check("midrst_clean", signal_clean, 32'h0);
      check("midrst_ovr",   {31'd0, overrun}, 32'h0);
      @(negedge clk_operation);
      rst = 1'b0;
      set_w(32'h0000_8000, 32'h0, 32'h0, 32'h0);
      run_sample(32'h0002_0000, 32'h0002_0000);
      check("postrst_echo",  signal_echo,  32'h0001_0000);
      check("postrst_clean", signal_clean, 32'h0001_0000);

      // Rounding half toward +inf. The weight is changed mid-sample and must
      // not be seen.
      run_sample(32'h0000_0001, 32'h0);
      check("rnd_pos_echo",  signal_echo,  32'h0000_0001);
      check("rnd_pos_clean", signal_clean, 32'hFFFF_FFFF);
      pulse_valid(32'hFFFF_FFFF, 32'h0000_0005);
      @(negedge clk_operation);
      para_0 = 32'h0001_0000;
      wait_ready();
      check("rnd_neg_echo",  signal_echo,  32'h0000_0000);
      check("rnd_neg_clean", signal_clean, 32'h0000_0005);
      @(negedge clk_operation);
      check("hold_echo", signal_echo, 32'h0000_0000);
      check("hold_clean", signal_clean, 32'h0000_0005);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
